// File: rtl/stat_stream_sequencer_pkg.sv
// rtl/stat_stream_sequencer_pkg.sv - shared types and constants for the statistics stream sequencer
package stat_stream_sequencer_pkg;

    localparam int SAMPLE_W = 4;
    localparam int RES_W    = 8;

    localparam logic [1:0] OP_MAX  = 2'd0;
    localparam logic [1:0] OP_MIN  = 2'd1;
    localparam logic [1:0] OP_MEAN = 2'd2;
    localparam logic [1:0] OP_VAR  = 2'd3;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ISSUE   = 2'd1,
        PRESENT = 2'd2
    } state_e;

endpackage

// File: rtl/stat_stream_sequencer_next_op.sv
// rtl/stat_stream_sequencer_next_op.sv - lowest set mask bit at or above base, plus last-op flag
module stat_next_op
    import stat_stream_sequencer_pkg::*;
(
    input  logic [3:0] mask,
    input  logic [2:0] base,
    output logic       found,
    output logic [1:0] next_idx,
    output logic       last
);

    // Descending scan so the lowest qualifying bit is the one left standing.
    always_comb begin
        found    = 1'b0;
        next_idx = OP_MAX;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= base)) begin
                found    = 1'b1;
                next_idx = 2'(i);
            end
        end
    end

    always_comb begin
        last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (mask[i] && (2'(i) > next_idx)) begin
                last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/stat_stream_sequencer.sv
// rtl/stat_stream_sequencer.sv - groups 4-bit samples in fours and sequences one-hot ops through the calculator
module stat_stream_sequencer
    import stat_stream_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                in_ready,
    input  logic [3:0]          op_mask,
    output logic [SAMPLE_W-1:0] calc_a,
    output logic [SAMPLE_W-1:0] calc_b,
    output logic [SAMPLE_W-1:0] calc_c,
    output logic [SAMPLE_W-1:0] calc_d,
    output logic [3:0]          calc_op,
    input  logic [RES_W-1:0]    calc_out,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [RES_W-1:0]    res_data,
    output logic [1:0]          res_op,
    output logic                res_last,
    output logic                busy
);

    state_e     state;
    logic [1:0] cnt;
    logic [3:0] mask_q;
    logic [1:0] op_idx;

    logic [3:0] sel_mask;
    logic [2:0] sel_base;
    logic       nxt_found;
    logic [1:0] nxt_idx;
    logic       nxt_last;

    // One selector serves three roles: first op (live mask), current op's last flag, and the following op.
    always_comb begin
        sel_mask = mask_q;
        sel_base = {1'b0, op_idx};
        case (state)
            COLLECT: begin
                sel_mask = op_mask;
                sel_base = {1'b0, OP_MAX};
            end
            PRESENT: sel_base = {1'b0, op_idx} + 3'd1;
            default: ;
        endcase
    end

    stat_next_op u_next_op (
        .mask     (sel_mask),
        .base     (sel_base),
        .found    (nxt_found),
        .next_idx (nxt_idx),
        .last     (nxt_last)
    );

    always_comb begin
        calc_op = 4'b0000;
        if (state == ISSUE) begin
            case (op_idx)
                OP_MAX:  calc_op = 4'b0001;
                OP_MIN:  calc_op = 4'b0010;
                OP_MEAN: calc_op = 4'b0100;
                OP_VAR:  calc_op = 4'b1000;
                default: calc_op = 4'b0000;
            endcase
        end
    end

    assign in_ready  = (state == COLLECT);
    assign busy      = (state != COLLECT);
    assign res_valid = (state == PRESENT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= COLLECT;
            cnt      <= 2'd0;
            calc_a   <= '0;
            calc_b   <= '0;
            calc_c   <= '0;
            calc_d   <= '0;
            mask_q   <= 4'd0;
            op_idx   <= OP_MAX;
            res_data <= '0;
            res_op   <= 2'd0;
            res_last <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (in_valid) begin
                        case (cnt)
                            2'd0:    calc_a <= in_data;
                            2'd1:    calc_b <= in_data;
                            2'd2:    calc_c <= in_data;
                            default: calc_d <= in_data;
                        endcase
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            mask_q <= op_mask;
                            if (nxt_found) begin
                                op_idx <= nxt_idx;
                                state  <= ISSUE;
                            end
                        end
                    end
                end
                ISSUE: begin
                    res_data <= calc_out;
                    res_op   <= op_idx;
                    res_last <= nxt_last;
                    state    <= PRESENT;
                end
                PRESENT: begin
                    if (res_ready) begin
                        if (res_last) begin
                            state <= COLLECT;
                        end else begin
                            op_idx <= nxt_idx;
                            state  <= ISSUE;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_stat_stream_sequencer.sv
// tb/tb_stat_stream_sequencer.sv - directed self-checking bench for stat_stream_sequencer
module tb_stat_stream_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic [3:0] op_mask;
    logic [3:0] calc_a, calc_b, calc_c, calc_d;
    logic [3:0] calc_op;
    logic [7:0] calc_out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [1:0] res_op;
    logic       res_last;
    logic       busy;
    logic       real_calc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stat_stream_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .op_mask   (op_mask),
        .calc_a    (calc_a),
        .calc_b    (calc_b),
        .calc_c    (calc_c),
        .calc_d    (calc_d),
        .calc_op   (calc_op),
        .calc_out  (calc_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
        .res_last  (res_last),
        .busy      (busy)
    );

    // Stub returns {A, op}; the behavioural calculator covers MAX/MIN/MEAN.
    logic [3:0] mx, mn;
    logic [5:0] sum;
    always_comb begin
        mx  = calc_a;
        mn  = calc_a;
        if (calc_b > mx) mx = calc_b;
        if (calc_c > mx) mx = calc_c;
        if (calc_d > mx) mx = calc_d;
        if (calc_b < mn) mn = calc_b;
        if (calc_c < mn) mn = calc_c;
        if (calc_d < mn) mn = calc_d;
        sum = 6'(calc_a) + 6'(calc_b) + 6'(calc_c) + 6'(calc_d);
        calc_out = {4'hA, calc_op};
        if (real_calc) begin
            case (calc_op)
                4'b0001: calc_out = {4'h0, mx};
                4'b0010: calc_out = {4'h0, mn};
                4'b0100: calc_out = {4'h0, sum[5:2]};
                default: calc_out = 8'h00;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] v);
        int n = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("push_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [7:0] d, input logic [1:0] op, input logic last);
        int n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, 32'(res_valid), 1);
        chk({tag, "_data"}, 32'(res_data), 32'(d));
        chk({tag, "_op"}, 32'(res_op), 32'(op));
        chk({tag, "_last"}, 32'(res_last), 32'(last));
        if (res_ready) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int bad;
        logic [7:0] hold_d;
        logic [1:0] hold_op;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        op_mask   = 4'b0000;
        res_ready = 1'b1;
        real_calc = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_calc_op", 32'(calc_op), 0);
        chk("rst_calc_a", 32'(calc_a), 0);
        chk("rst_res_data", 32'(res_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All four ops in order.
        op_mask = 4'b1111;
        push(4'd2); push(4'd6); push(4'd4); push(4'd8);
        chk("t1_issue_calc_op", 32'(calc_op), 32'h1);
        chk("t1_issue_in_ready", 32'(in_ready), 0);
        chk("t1_issue_busy", 32'(busy), 1);
        @(posedge clk); #1;
        chk("t1_calc_op_present", 32'(calc_op), 0);
        chk("t1_operands", {16'h0, calc_a, calc_b, calc_c, calc_d}, 32'h2648);
        expect_result("t1_r0", 8'hA1, 2'd0, 1'b0);
        chk("t1_issue2_calc_op", 32'(calc_op), 32'h2);
        expect_result("t1_r1", 8'hA2, 2'd1, 1'b0);
        expect_result("t1_r2", 8'hA4, 2'd2, 1'b0);
        expect_result("t1_r3", 8'hA8, 2'd3, 1'b1);
        chk("t1_in_ready_after", 32'(in_ready), 1);

        // Sparse mask plus exact latency.
        op_mask = 4'b0101;
        push(4'd1); push(4'd2); push(4'd3); push(4'd4);
        chk("t2_lat_n1", 32'(res_valid), 0);
        @(posedge clk); #1;
        chk("t2_lat_n2", 32'(res_valid), 1);
        expect_result("t2_r0", 8'hA1, 2'd0, 1'b0);
        expect_result("t2_r1", 8'hA4, 2'd2, 1'b1);
        chk("t2_no_more", 32'(res_valid), 0);

        // Empty mask: group absorbed silently, next four start fresh.
        op_mask = 4'b0000;
        push(4'd9); push(4'd9); push(4'd9); push(4'd9);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (res_valid !== 1'b0 || in_ready !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        chk("t3_idle", 32'(bad), 0);
        op_mask = 4'b0001;
        push(4'd1); push(4'd2); push(4'd3); push(4'd4);
        expect_result("t3_r0", 8'hA1, 2'd0, 1'b1);
        chk("t3_operands", {16'h0, calc_a, calc_b, calc_c, calc_d}, 32'h1234);

        // Mask latched on 4th accept only; then a long stall.
        op_mask   = 4'b1111;
        res_ready = 1'b0;
        push(4'd5); push(4'd5); push(4'd5);
        op_mask = 4'b1000;
        push(4'd5);
        op_mask = 4'b0001;
        @(posedge clk); #1;
        chk("t4_valid", 32'(res_valid), 1);
        hold_d  = res_data;
        hold_op = res_op;
        bad = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b1 || res_data !== hold_d || res_op !== hold_op ||
                in_ready !== 1'b0 || calc_op !== 4'b0000) bad++;
        end
        in_valid = 1'b0;
        chk("t4_stall_stable", 32'(bad), 0);
        res_ready = 1'b1;
        expect_result("t4_r0", 8'hA8, 2'd3, 1'b1);
        chk("t4_in_ready_after", 32'(in_ready), 1);

        // Async reset while presenting.
        op_mask   = 4'b0011;
        res_ready = 1'b0;
        push(4'd7); push(4'd7); push(4'd7); push(4'd7);
        @(posedge clk); #1;
        chk("t5_pre_valid", 32'(res_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(res_valid), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_in_ready", 32'(in_ready), 1);
        chk("t5_rst_calc_a", 32'(calc_a), 0);
        chk("t5_rst_res_data", 32'(res_data), 0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        res_ready = 1'b1;
        op_mask   = 4'b0010;
        push(4'd3); push(4'd1); push(4'd4); push(4'd1);
        expect_result("t5_r0", 8'hA2, 2'd1, 1'b1);
        chk("t5_operands", {16'h0, calc_a, calc_b, calc_c, calc_d}, 32'h3141);

        // Behavioural calculator.
        real_calc = 1'b1;
        op_mask   = 4'b0111;
        push(4'd2); push(4'd6); push(4'd4); push(4'd8);
        expect_result("t6_max", 8'd8, 2'd0, 1'b0);
        expect_result("t6_min", 8'd2, 2'd1, 1'b0);
        expect_result("t6_mean", 8'd5, 2'd2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
